// File: rtl/rv_isa_pkg.sv
// ============================================================================
// Module   : rv_isa_pkg
// Brief    : RV32I instruction formats, opcode constants and instruction layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_isa_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // R-type slot layout; other formats reuse the slots for immediate bits.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

endpackage

`default_nettype wire

// File: rtl/rv_field_pack.sv
// ============================================================================
// Module   : rv_field_pack
// Brief    : Combinational packer from decoded fields to an RV32I word + error.
//            Macro RV_ENC_IMM_CHECK_EN adds immediate range/alignment errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_field_pack
    import rv_isa_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    instr_t w_ins;
    logic   w_fmt_ok;
    logic   w_range_bad;

    always_comb begin
        w_ins        = '0;
        w_ins.opcode = opcode;
        w_ins.funct3 = funct3;
        w_ins.rs1    = rs1;
        w_ins.rs2    = rs2;
        w_ins.rd     = rd;
        w_ins.funct7 = funct7;
        w_fmt_ok     = 1'b1;
        case (fmt)
            FMT_R: ;
            FMT_I: {w_ins.funct7, w_ins.rs2} = imm[11:0];
            FMT_S: begin
                w_ins.funct7 = imm[11:5];
                w_ins.rd     = imm[4:0];
            end
            FMT_B: begin
                w_ins.funct7 = {imm[12], imm[10:5]};
                w_ins.rd     = {imm[4:1], imm[11]};
            end
            FMT_U: {w_ins.funct7, w_ins.rs2, w_ins.rs1, w_ins.funct3} = imm[31:12];
            FMT_J: {w_ins.funct7, w_ins.rs2, w_ins.rs1, w_ins.funct3} =
                       {imm[20], imm[10:1], imm[11], imm[19:12]};
            default: w_fmt_ok = 1'b0;
        endcase
    end

`ifdef RV_ENC_IMM_CHECK_EN
    // A sign-extended field fits when every bit above its top bit matches it.
    always_comb begin
        w_range_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: w_range_bad = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        w_range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_J:        w_range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            FMT_U:        w_range_bad = |imm[11:0];
            default:      w_range_bad = 1'b0;
        endcase
    end
`else
    logic w_unused_imm0;
    assign w_unused_imm0 = imm[0];
    assign w_range_bad   = 1'b0;
`endif

    assign word = w_fmt_ok ? w_ins : NOP_WORD;
    assign err  = !w_fmt_ok || w_range_bad;

endmodule

`default_nettype wire

// File: rtl/rv_instr_encoder.sv
// ============================================================================
// Module   : rv_instr_encoder
// Brief    : Field bundle -> RV32I word encoder with address-stamped output FIFO.
//            Macro RV_ENC_IMM_CHECK_EN enables immediate range errors on out_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int                DEPTH     = 2,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   c_depth = DEPTH[PTR_W:0];
    localparam logic [ADDR_W-1:0] c_step = ADDR_W'(4);

    logic [31:0]       r_mem_instr [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
    logic              r_mem_err   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_addr;

    logic [31:0] w_word;
    logic        w_err;
    logic        w_full;
    logic        w_push;
    logic        w_pop;

    rv_field_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .rd     (in_rd),
        .imm    (in_imm),
        .word   (w_word),
        .err    (w_err)
    );

    // in_ready depends only on occupancy, so a pop cannot open the FIFO the same cycle.
    assign w_full    = (r_count == c_depth);
    assign in_ready  = !w_full && !flush && !rst;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;

    assign out_instr = r_mem_instr[r_rd_ptr];
    assign out_addr  = r_mem_addr[r_rd_ptr];
    assign out_err   = r_mem_err[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_addr[i]  <= BASE_ADDR;
                r_mem_err[i]   <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_instr[r_wr_ptr] <= w_word;
            r_mem_addr[r_wr_ptr]  <= r_addr;
            r_mem_err[r_wr_ptr]   <= w_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_addr   <= r_addr + c_step;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire
